// File: rtl/aes_pkg.sv
// Shared types, widths and the key-schedule rotate for the nibble-cell round sequencer.
package aes_pkg;

  localparam int ROW_W = 16;
  localparam int BLK_W = 64;
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_t;

  // Whole-block rotate left by one nibble; this is the round-key schedule step.
  function automatic logic [BLK_W-1:0] rotl4_64(input logic [BLK_W-1:0] v);
    return {v[BLK_W-5:0], v[BLK_W-1:BLK_W-4]};
  endfunction

endpackage

// File: rtl/nibble_shift_rows.sv
// Combinational ShiftRows for a 64-bit block of four 16-bit rows (row0 in the MSBs).
module nibble_shift_rows
  import aes_pkg::*;
(
  input  logic [BLK_W-1:0] blk_i,
  output logic [BLK_W-1:0] blk_o
);

  logic [ROW_W-1:0] row0;
  logic [ROW_W-1:0] row1;
  logic [ROW_W-1:0] row2;
  logic [ROW_W-1:0] row3;

  assign row0 = blk_i[63:48];
  assign row1 = blk_i[47:32];
  assign row2 = blk_i[31:16];
  assign row3 = blk_i[15:0];

  // Right rotates by 12, 8 and 4 bits for rows 1..3; row0 passes through.
  assign blk_o = {row0,
                  row1[11:0], row1[15:12],
                  row2[7:0],  row2[15:8],
                  row3[3:0],  row3[15:4]};

endmodule

// File: rtl/aes_round_sequencer.sv
// Round controller: accepts a block and key, runs NUM_ROUNDS ShiftRows+key rounds,
// then holds the ciphertext on a valid/ready output until consumed.
module aes_round_sequencer
  import aes_pkg::*;
#(
  parameter int NUM_ROUNDS = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             abort,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [BLK_W-1:0] in_data,
  input  logic [BLK_W-1:0] in_key,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BLK_W-1:0] out_data,
  output logic             busy,
  output logic [CNT_W-1:0] round_cnt
);

  localparam logic [CNT_W-1:0] LAST_ROUND = CNT_W'(NUM_ROUNDS);

  seq_state_t       fsm_q, fsm_d;
  logic [BLK_W-1:0] state_q, state_d;
  logic [BLK_W-1:0] key_q, key_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             init_q, init_d;
  logic [BLK_W-1:0] key_next;
  logic [BLK_W-1:0] sr_out;

  nibble_shift_rows u_shift_rows (
    .blk_i (state_q),
    .blk_o (sr_out)
  );

  assign key_next = rotl4_64(key_q);
  // init_q keeps in_ready low while reset is held, and for no longer.
  assign init_d   = 1'b1;

  assign in_ready  = (fsm_q == IDLE) && init_q;
  assign out_valid = (fsm_q == DONE);
  assign out_data  = state_q;
  assign busy      = (fsm_q == RUN) || (fsm_q == DONE);
  assign round_cnt = cnt_q;

  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    key_d   = key_q;
    cnt_d   = cnt_q;
    if (abort) begin
      fsm_d   = IDLE;
      state_d = '0;
      key_d   = '0;
      cnt_d   = '0;
    end else begin
      unique case (fsm_q)
        IDLE: begin
          if (in_valid && in_ready) begin
            state_d = in_data ^ in_key;
            key_d   = in_key;
            cnt_d   = CNT_W'(1);
            fsm_d   = RUN;
          end
        end
        RUN: begin
          key_d   = key_next;
          state_d = sr_out ^ key_next;
          if (cnt_q == LAST_ROUND) begin
            fsm_d = DONE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            fsm_d = IDLE;
            cnt_d = '0;
          end
        end
        default: begin
          fsm_d = IDLE;
          cnt_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q   <= IDLE;
      state_q <= '0;
      key_q   <= '0;
      cnt_q   <= '0;
      init_q  <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      key_q   <= key_d;
      cnt_q   <= cnt_d;
      init_q  <= init_d;
    end
  end

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Self-checking bench: constant vectors on a 1-round instance, scoreboard and corner
// sequences on a 4-round instance.
module tb_aes_round_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        abort1 = 0, in_valid1 = 0, out_ready1 = 0;
  logic        in_ready1, out_valid1, busy1;
  logic [63:0] in_data1 = '0, in_key1 = '0, out_data1;
  logic [3:0]  round_cnt1;

  logic        abort4 = 0, in_valid4 = 0, out_ready4 = 0;
  logic        in_ready4, out_valid4, busy4;
  logic [63:0] in_data4 = '0, in_key4 = '0, out_data4;
  logic [3:0]  round_cnt4;

  aes_round_sequencer #(.NUM_ROUNDS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .abort(abort1),
    .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1), .in_key(in_key1),
    .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1),
    .busy(busy1), .round_cnt(round_cnt1)
  );

  aes_round_sequencer #(.NUM_ROUNDS(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .abort(abort4),
    .in_valid(in_valid4), .in_ready(in_ready4), .in_data(in_data4), .in_key(in_key4),
    .out_valid(out_valid4), .out_ready(out_ready4), .out_data(out_data4),
    .busy(busy4), .round_cnt(round_cnt4)
  );

  int checks = 0;
  int errors = 0;
  logic [63:0] sb_q[$];

  typedef struct {
    logic [63:0] data;
    logic [63:0] key;
    logic [63:0] exp_out;
  } vec_t;
  vec_t vecs[3];

  int exp_cnt[6]   = '{0, 1, 2, 3, 4, 4};
  int exp_ready[6] = '{1, 0, 0, 0, 0, 0};
  int exp_ovld[6]  = '{0, 0, 0, 0, 0, 1};

  function automatic logic [63:0] sr_ref(input logic [63:0] s);
    logic [15:0] r1, r2, r3;
    r1 = s[47:32];
    r2 = s[31:16];
    r3 = s[15:0];
    return {s[63:48], r1[11:0], r1[15:12], r2[7:0], r2[15:8], r3[3:0], r3[15:4]};
  endfunction

  function automatic logic [63:0] cipher_ref(input logic [63:0] d, input logic [63:0] k,
                                             input int nr);
    logic [63:0] s, kk;
    s  = d ^ k;
    kk = k;
    for (int r = 0; r < nr; r++) begin
      kk = {kk[59:0], kk[63:60]};
      s  = sr_ref(s) ^ kk;
    end
    return s;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Runs one block through dut4; optionally leaves the result pending in DONE.
  task automatic applyStimulus(input logic [63:0] d, input logic [63:0] k,
                               input string name, input bit accept);
    int waitc;
    logic [63:0] exp;
    exp = cipher_ref(d, k, 4);
    @(negedge clk);
    waitc = 0;
    while (!in_ready4 && waitc < 20) begin
      @(negedge clk);
      waitc++;
    end
    checkOutput({name, "_in_ready"}, in_ready4, 1);
    in_valid4 = 1; in_data4 = d; in_key4 = k; out_ready4 = 0;
    @(negedge clk);
    in_valid4 = 0;
    waitc = 0;
    while (!out_valid4 && waitc < 20) begin
      @(negedge clk);
      waitc++;
    end
    checkOutput({name, "_out_valid"}, out_valid4, 1);
    checkOutput({name, "_out_data"}, out_data4, exp);
    if (accept) begin
      out_ready4 = 1;
      @(negedge clk);
      out_ready4 = 0;
    end
  endtask

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int blocks_done;
    int cycles;
    bit prev_hold;
    bit saw_valid;
    logic [63:0] prev_data;
    logic [63:0] d, k;

    vecs[0] = '{64'h0123_4567_89AB_CDEF, 64'h0, 64'h0123_5674_AB89_FCDE};
    vecs[1] = '{64'h0, 64'h1, 64'h0000_0000_0000_1010};
    vecs[2] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF};

    // Reset state
    #12;
    checkOutput("rst_in_ready_low", in_ready4, 0);
    checkOutput("rst_out_valid", out_valid4, 0);
    checkOutput("rst_out_data", out_data4, 0);
    checkOutput("rst_busy", busy4, 0);
    checkOutput("rst_round_cnt", round_cnt4, 0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    checkOutput("rel_in_ready4", in_ready4, 1);
    checkOutput("rel_in_ready1", in_ready1, 1);

    // Constant vectors on the 1-round instance
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid1 = 1; in_data1 = vecs[i].data; in_key1 = vecs[i].key; out_ready1 = 1;
      checkOutput("vec_in_ready", in_ready1, 1);
      @(negedge clk);
      in_valid1 = 0;
      checkOutput("vec_c1_out_valid", out_valid1, 0);
      checkOutput("vec_c1_busy", busy1, 1);
      checkOutput("vec_c1_cnt", round_cnt1, 1);
      @(negedge clk);
      checkOutput("vec_c2_out_valid", out_valid1, 1);
      checkOutput("vec_c2_out_data", out_data1, vecs[i].exp_out);
      @(negedge clk);
      checkOutput("vec_c3_in_ready", in_ready1, 1);
      checkOutput("vec_c3_cnt", round_cnt1, 0);
      out_ready1 = 0;
    end

    // Back-to-back throughput on the 4-round instance
    @(negedge clk);
    d = 64'hDEAD_BEEF_0BAD_F00D;
    k = 64'h1357_9BDF_2468_ACE0;
    in_valid4 = 1; in_data4 = d; in_key4 = k; out_ready4 = 1;
    for (int j = 0; j <= 12; j++) begin
      if (j > 0) @(negedge clk);
      checkOutput("thr_round_cnt", round_cnt4, exp_cnt[j % 6]);
      checkOutput("thr_in_ready", in_ready4, exp_ready[j % 6]);
      checkOutput("thr_out_valid", out_valid4, exp_ovld[j % 6]);
      if (j % 6 == 5) checkOutput("thr_out_data", out_data4, cipher_ref(d, k, 4));
      if (j == 12) in_valid4 = 0;
    end
    out_ready4 = 0;

    // Abort in round 2
    @(negedge clk);
    in_valid4 = 1; in_data4 = 64'hAAAA_5555_AAAA_5555; in_key4 = 64'h1234; out_ready4 = 1;
    @(negedge clk);
    in_valid4 = 0;
    @(negedge clk);
    checkOutput("abort_pre_cnt", round_cnt4, 2);
    abort4 = 1;
    @(negedge clk);
    abort4 = 0;
    checkOutput("abort_in_ready", in_ready4, 1);
    checkOutput("abort_cnt", round_cnt4, 0);
    checkOutput("abort_busy", busy4, 0);
    checkOutput("abort_out_data", out_data4, 0);
    saw_valid = 0;
    for (int j = 0; j < 8; j++) begin
      if (out_valid4) saw_valid = 1;
      @(negedge clk);
    end
    checkOutput("abort_no_out_valid", saw_valid, 0);
    out_ready4 = 0;
    applyStimulus(64'h0F1E_2D3C_4B5A_6978, 64'hFEDC_BA98_7654_3210, "post_abort", 1);

    // Random blocks with throttled consumer
    blocks_done = 0;
    cycles = 0;
    prev_hold = 0;
    prev_data = '0;
    while (blocks_done < 1000 && cycles < 40000) begin
      @(negedge clk);
      cycles++;
      if (prev_hold) begin
        checkOutput("rnd_hold_valid", out_valid4, 1);
        checkOutput("rnd_hold_data", out_data4, prev_data);
      end
      if (busy4) checkOutput("rnd_ready_busy", in_ready4, 0);
      in_valid4  = 1'($urandom_range(0, 1));
      in_data4   = {$urandom, $urandom};
      in_key4    = {$urandom, $urandom};
      out_ready4 = ($urandom_range(0, 2) != 0);
      if (in_valid4 && in_ready4) sb_q.push_back(cipher_ref(in_data4, in_key4, 4));
      if (out_valid4 && out_ready4) begin
        if (sb_q.size() == 0) checkOutput("rnd_sb_underflow", out_data4, 64'hX);
        else checkOutput("rnd_out_data", out_data4, sb_q.pop_front());
        blocks_done++;
      end
      prev_hold = out_valid4 && !out_ready4;
      prev_data = out_data4;
    end
    in_valid4 = 0;
    checkOutput("rnd_blocks_done", blocks_done, 1000);
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      out_ready4 = 1;
      if (out_valid4 && out_ready4 && sb_q.size() != 0)
        checkOutput("drain_out_data", out_data4, sb_q.pop_front());
    end
    out_ready4 = 0;
    checkOutput("sb_empty", sb_q.size(), 0);

    // Reset while DONE is pending
    applyStimulus(64'h1111_2222_3333_4444, 64'h0000_0000_0000_0001, "pend", 0);
    #2;
    rst_n = 0;
    #1;
    checkOutput("async_out_valid", out_valid4, 0);
    checkOutput("async_in_ready", in_ready4, 0);
    checkOutput("async_out_data", out_data4, 0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    checkOutput("rel2_in_ready", in_ready4, 1);
    checkOutput("rel2_out_valid", out_valid4, 0);
    checkOutput("rel2_out_data", out_data4, 0);
    checkOutput("rel2_busy", busy4, 0);
    checkOutput("rel2_round_cnt", round_cnt4, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
